// File: rtl/audio_stream_predelay.sv
// Left-channel predelay: each accepted sample is written to a circular buffer and the sample D beats older is returned.
// Latency 2 cycles sink beat -> src_valid; sink is held off until the source beat completes (stalls in HOLD while src_ready is low).
module audio_stream_predelay #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    input  logic [23:0]       predelay_value,
    input  logic              bypass
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] d_eff;
    logic [ADDR_W-1:0] d_lat;
    logic [ADDR_W:0]   fill;
    logic [DATA_W-1:0] in_lat;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_reg;
    logic              zero_flag;
    logic              out_vld;
    logic              snk_beat;
    logic              src_beat;

    // Delay is clamped to the oldest slot still holding a retained sample.
    always_comb begin
        d_eff = '0;
        if (!bypass) begin
            if (predelay_value > 24'(DEPTH - 1))
                d_eff = '1;
            else
                d_eff = predelay_value[ADDR_W-1:0];
        end
    end

    assign ra       = wp - d_eff;
    assign snk_beat = snk_valid && snk_ready;
    assign src_beat = out_vld && src_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snk_beat) state_nxt = READ;
            READ:    state_nxt = HOLD;
            HOLD:    if (src_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by reset_n so the sink is closed for the whole time reset is held.
    always_comb begin
        snk_ready = reset_n && (state == IDLE);
        src_valid = out_vld;
        src_data  = out_reg;
    end

    // Buffer is never cleared; fill masks slots that were never written.
    always_ff @(posedge clk) begin
        if (snk_beat) begin
            mem[wp] <= snk_data;
            rd_data <= mem[ra];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            fill      <= '0;
            d_lat     <= '0;
            in_lat    <= '0;
            zero_flag <= 1'b0;
            out_reg   <= '0;
            out_vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (snk_beat) begin
                        d_lat     <= d_eff;
                        in_lat    <= snk_data;
                        zero_flag <= ({1'b0, d_eff} > fill);
                    end
                end
                READ: begin
                    if (d_lat == '0)
                        out_reg <= in_lat;
                    else if (zero_flag)
                        out_reg <= '0;
                    else
                        out_reg <= rd_data;
                    out_vld <= 1'b1;
                    wp      <= wp + 1'b1;
                    if (fill != (ADDR_W+1)'(DEPTH))
                        fill <= fill + 1'b1;
                end
                HOLD: begin
                    if (src_ready)
                        out_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_stream_predelay.sv
// Directed bench for audio_stream_predelay: vector table plus back-pressure, long-clamp and reset sequences.
module tb_audio_stream_predelay;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [23:0] src_data;
    logic        src_valid;
    logic        src_ready = 1'b1;
    logic [23:0] predelay_value = '0;
    logic        bypass = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [23:0] pv;
        logic        byp;
        logic [23:0] din;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[15];

    audio_stream_predelay #(.DATA_W(24), .ADDR_W(12)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .predelay_value (predelay_value),
        .bypass         (bypass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_src_valid", {31'd0, src_valid}, 0);
        chk("rst_snk_ready", {31'd0, snk_ready}, 0);
        chk("rst_src_data", {8'd0, src_data}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One sample through the block; leaves the DUT in HOLD when src_ready is low.
    task automatic do_beat(input logic [23:0] din, input logic [23:0] pv,
                           input logic byp, input logic [23:0] exp);
        int t = 0;
        while (!snk_ready && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        if (!snk_ready) begin
            chk("snk_ready_timeout", {31'd0, snk_ready}, 1);
            return;
        end
        snk_data       = din;
        snk_valid      = 1'b1;
        predelay_value = pv;
        bypass         = byp;
        @(posedge clk); #1;
        snk_valid = 1'b0;
        bypass    = 1'b0;
        chk("lat_valid_lo", {31'd0, src_valid}, 0);
        chk("snk_ready_read", {31'd0, snk_ready}, 0);
        @(posedge clk); #1;
        chk("lat_valid_hi", {31'd0, src_valid}, 1);
        chk("data", {8'd0, src_data}, {8'd0, exp});
        chk("snk_ready_hold", {31'd0, snk_ready}, 0);
        if (src_ready) begin
            @(posedge clk); #1;
            chk("valid_drop", {31'd0, src_valid}, 0);
            chk("snk_ready_idle", {31'd0, snk_ready}, 1);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 24'd0, 1'b0, 24'd1,  24'd1};
        vecs[1]  = '{1'b0, 24'd0, 1'b0, 24'd2,  24'd2};
        vecs[2]  = '{1'b0, 24'd0, 1'b0, 24'd3,  24'd3};
        vecs[3]  = '{1'b1, 24'd3, 1'b0, 24'd10, 24'd0};
        vecs[4]  = '{1'b0, 24'd3, 1'b0, 24'd20, 24'd0};
        vecs[5]  = '{1'b0, 24'd3, 1'b0, 24'd30, 24'd0};
        vecs[6]  = '{1'b0, 24'd3, 1'b0, 24'd40, 24'd10};
        vecs[7]  = '{1'b0, 24'd3, 1'b0, 24'd50, 24'd20};
        vecs[8]  = '{1'b0, 24'd3, 1'b0, 24'd60, 24'd30};
        vecs[9]  = '{1'b1, 24'd2, 1'b0, 24'd1,  24'd0};
        vecs[10] = '{1'b0, 24'd2, 1'b0, 24'd2,  24'd0};
        vecs[11] = '{1'b0, 24'd2, 1'b0, 24'd3,  24'd1};
        vecs[12] = '{1'b0, 24'd2, 1'b1, 24'd4,  24'd4};
        vecs[13] = '{1'b0, 24'd2, 1'b0, 24'd5,  24'd3};
        vecs[14] = '{1'b0, 24'd2, 1'b0, 24'd6,  24'd4};

        #2;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst)
                do_reset();
            do_beat(vecs[i].din, vecs[i].pv, vecs[i].byp, vecs[i].exp);
        end

        // Clamp to 4095 and wrap of the write pointer.
        do_reset();
        for (int n = 1; n <= 4100; n++)
            do_beat(24'(n), 24'd5000, 1'b0, (n <= 4095) ? 24'd0 : 24'(n - 4095));

        // Back-pressure: output must hold steady while the sink stays closed.
        do_reset();
        src_ready = 1'b0;
        do_beat(24'd100, 24'd0, 1'b0, 24'd100);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, src_valid}, 1);
            chk("bp_data", {8'd0, src_data}, 100);
            chk("bp_snk_ready", {31'd0, snk_ready}, 0);
        end
        src_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {31'd0, src_valid}, 0);
        do_beat(24'd101, 24'd0, 1'b0, 24'd101);

        // Reset while a sample is pending in HOLD.
        do_reset();
        src_ready = 1'b0;
        do_beat(24'd5, 24'd1, 1'b0, 24'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_src_valid", {31'd0, src_valid}, 0);
        chk("mid_rst_snk_ready", {31'd0, snk_ready}, 0);
        chk("mid_rst_src_data", {8'd0, src_data}, 0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        src_ready = 1'b1;
        @(posedge clk); #1;
        do_beat(24'd7, 24'd1, 1'b0, 24'd0);
        do_beat(24'd8, 24'd1, 1'b0, 24'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
